psx_joy_port: RTL
=================

// Module: psx_joy_port
// PURPOSE
//  Controller/memory-card serial port (JOY_DATA..JOY_BAUD, 0x1F801040-0x1F80104F), fed by io_controller.
//  - Byte-wide shift engine with baud divider and RX FIFO; drives pad/card serial pins.
//  - Raises the controller IRQ (I_STAT bit 7) on pad /ACK.
// PARAMETERS
//  RX_DEPTH     8        RX FIFO entries (power of 2, >=2)
//  BAUD_RESET   16'h0088 JOY_BAUD reset value
//  ACK_TIMEOUT  1024     clk cycles to wait for /ACK (used only with JOY_ACK_TIMEOUT_EN)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous, active-high reset
//  reg_sel    in   4   addr[3:0]: 0x0 DATA, 0x4 STAT, 0x8 MODE[15:0]/CTRL[31:16], 0xC BAUD[31:16]
//  wen        in   1   register write strobe from io_controller
//  ren        in   1   register read strobe from io_controller
//  ben        in   4   byte enables for writes
//  data_i     in   32  write data
//  data_o     out  32  read data, registered
//  joy_clk    out  1   serial clock, idles high
//  joy_txd    out  1   serial data out, idles high
//  joy_rxd    in   1   serial data in
//  joy_ack_n  in   1   pad/card acknowledge, active low (pre-synchronised)
//  joy_sel_n  out  2   slot selects, active low
//  irq_ctrl   out  1   level IRQ to interrupt controller (= STAT[9])
// BEHAVIOUR
//  Reset (rst): all outputs 0 except joy_clk=1, joy_txd=1, joy_sel_n=2'b11; FIFO empty; CTRL=MODE=0; BAUD=BAUD_RESET.
//  Reads: data_o valid the cycle after ren first seen high (ren & ~ren_q); holds until next read.
//   DATA read pops one FIFO byte into data_o[7:0], upper bits 0; read of empty FIFO returns 0, no pop.
//  STAT: [0] TX buffer empty, [1] RX FIFO not empty, [2] shifter idle, [4] RX overrun (sticky),
//   [7] ~joy_ack_n, [9] IRQ flag, others 0.
//  CTRL: [0] TXEN, [1] JOYn assert, [4] ACK (W1: clear STAT[9],[4]; reads 0), [6] RESET (W1: reads 0),
//   [12] ACK IRQ enable, [13] slot select. joy_sel_n[CTRL13] = ~CTRL1; other bit 1.
//  Writes honour ben; DATA write (ben[0]) loads the single TX buffer, overwriting if already full.
//  CTRL.RESET: FSM->IDLE, FIFO empty, TX buffer empty, STAT flags clear, pins idle; MODE/BAUD kept.
//  Baud: half-period = BAUD cycles (BAUD==0 treated as 1); joy_clk period 2*BAUD.
//  FSM states:
//   IDLE     TX buffer full && TXEN -> LOAD
//   LOAD     copy buffer to shifter, buffer empty, bit=0 -> SHIFT_LO
//   SHIFT_LO joy_clk=0, joy_txd=shift[bit] (LSB first); after BAUD cycles -> SHIFT_HI
//   SHIFT_HI joy_clk=1, sample joy_rxd on entry; after BAUD cycles bit++; bit==8 -> DONE else SHIFT_LO
//   DONE     push RX byte (FIFO full: drop, set STAT[4]) -> ACK_WAIT
//   ACK_WAIT joy_ack_n==0: if CTRL12 set STAT[9]; -> IDLE. New TX byte with TXEN: -> LOAD, no IRQ.
//  Per byte: 1 LOAD + 16*BAUD shift + 1 DONE cycles.
//  Simultaneous FIFO push+pop: both occur, count unchanged; on empty FIFO, pop returns 0 and push is kept.
//  Simultaneous ACK-set and CTRL.ACK clear: set wins.
//  TXEN cleared mid-byte: current byte completes; next byte does not start.
//  rst or CTRL.RESET mid-byte: abort at once; partial RX byte discarded.
// CONFIGURATION
//  JOY_ACK_TIMEOUT_EN defined: ACK_WAIT counts cycles; at ACK_TIMEOUT with no /ACK -> IDLE, no IRQ.
//  Undefined: ACK_WAIT has no timeout; exit only on /ACK, new TX byte, CTRL.RESET or rst. ACK_TIMEOUT ignored.
// TESTING
//  1 BAUD=4, CTRL=0x1003, DATA<=0x01, rxd drives 0x41 -> txd LSB-first 1,0,0,0,0,0,0,0; joy_clk period 8;
//    joy_sel_n=2'b10; FIFO gets 0x41; STAT[1]=1.
//  2 After test 1, pulse joy_ack_n low 1 cycle -> STAT[9]=1, irq_ctrl=1; write CTRL[4]=1 -> both 0.
//  3 Send RX_DEPTH+1 bytes without reads -> STAT[4]=1, FIFO keeps first 8; 8 DATA reads return in order, 9th returns 0.
//  4 CTRL.RESET written during SHIFT_LO of bit 3 -> next cycle joy_clk=1, joy_txd=1, STAT=0x5, FIFO empty.
//  5 JOY_ACK_TIMEOUT_EN, ACK_TIMEOUT=16, no /ACK -> STAT[2]=1 after 16 cycles, irq_ctrl=0.
//    Without the macro -> FSM stays in ACK_WAIT.
//  6 BAUD written 0 -> joy_clk period 2 cycles.
//    DATA write while a byte shifts -> second byte starts one cycle after first DONE+ACK_WAIT exit.

Source files
------------

// File: rtl/psx_joy_port.sv
// PSX controller / memory-card serial port: register file, baud-timed byte shifter and RX FIFO.
// Optional ACK_WAIT timeout is compiled in when JOY_ACK_TIMEOUT_EN is defined.
`timescale 1ns/1ps

module psx_joy_port #(
   parameter int          RX_DEPTH    = 8,
   parameter logic [15:0] BAUD_RESET  = 16'h0088,
   parameter int          ACK_TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  reg_sel,
   input  logic        wen,
   input  logic        ren,
   input  logic [3:0]  ben,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        joy_clk,
   output logic        joy_txd,
   input  logic        joy_rxd,
   input  logic        joy_ack_n,
   output logic [1:0]  joy_sel_n,
   output logic        irq_ctrl
);

   localparam int AW = $clog2(RX_DEPTH);

`ifdef JOY_ACK_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SHIFT_LO, S_SHIFT_HI, S_DONE, S_ACK_WAIT
   } state_t;

   state_t state, state_d;

   logic [15:0]   mode;
   logic [15:0]   baud;
   logic          ctrl_txen, ctrl_joyn, ctrl_irqen, ctrl_slot;
   logic [7:0]    tx_buf;
   logic          tx_full;
   logic [7:0]    tx_shift, rx_shift;
   logic [2:0]    bit_idx;
   logic [15:0]   baud_cnt;
   logic [31:0]   tmo_cnt;
   logic          overrun, irq_flag, ren_q;
   logic [7:0]    fifo_mem [RX_DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr;
   logic [31:0]   rd_mux;

   logic          wr_data, soft_rst, ack_wr, rd_stb, pop, push, push_ok, ovr_set, ack_set;
   logic          fifo_empty, fifo_full, baud_last, ack_tmo;
   logic [15:0]   half_period;

   assign wr_data  = wen && (reg_sel == 4'h0) && ben[0];
   assign soft_rst = wen && (reg_sel == 4'h8) && ben[2] && data_i[22];
   assign ack_wr   = wen && (reg_sel == 4'h8) && ben[2] && data_i[20];
   assign rd_stb   = ren && !ren_q;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop        = rd_stb && (reg_sel == 4'h0) && !fifo_empty;
   assign push       = (state == S_DONE);
   // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
   assign push_ok    = push && (!fifo_full || pop);
   assign ovr_set    = push && fifo_full && !pop;
   assign ack_set    = (state == S_ACK_WAIT) && !joy_ack_n && ctrl_irqen;

   assign half_period = (baud == 16'd0) ? 16'd1 : baud;
   assign baud_last   = (baud_cnt == half_period - 16'd1);
   assign ack_tmo     = TMO_EN && (state == S_ACK_WAIT) && (tmo_cnt == 32'(ACK_TIMEOUT - 1));

   assign irq_ctrl  = irq_flag;
   assign joy_sel_n = ctrl_slot ? {~ctrl_joyn, 1'b1} : {1'b1, ~ctrl_joyn};

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_d;
   end

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      state_d = state;
      joy_clk = 1'b1;
      joy_txd = 1'b1;
      case (state)
         S_IDLE:     if (tx_full && ctrl_txen) state_d = S_LOAD;
         S_LOAD:     state_d = S_SHIFT_LO;
         S_SHIFT_LO: begin
            joy_clk = 1'b0;
            joy_txd = tx_shift[bit_idx];
            if (baud_last) state_d = S_SHIFT_HI;
         end
         S_SHIFT_HI: begin
            joy_txd = tx_shift[bit_idx];
            if (baud_last) state_d = (bit_idx == 3'd7) ? S_DONE : S_SHIFT_LO;
         end
         S_DONE:     state_d = S_ACK_WAIT;
         S_ACK_WAIT: begin
            if (!joy_ack_n)                 state_d = S_IDLE;
            else if (tx_full && ctrl_txen)  state_d = S_LOAD;
            else if (ack_tmo)               state_d = S_IDLE;
         end
         default:    state_d = S_IDLE;
      endcase
      if (soft_rst) state_d = S_IDLE;
   end

   // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || soft_rst) begin
         baud_cnt <= '0;
         bit_idx  <= '0;
         tx_shift <= '0;
         rx_shift <= '0;
         tmo_cnt  <= '0;
      end else begin
         baud_cnt <= ((state == S_SHIFT_LO || state == S_SHIFT_HI) && !baud_last)
                     ? baud_cnt + 16'd1 : 16'd0;
         tmo_cnt  <= (state == S_ACK_WAIT) ? tmo_cnt + 32'd1 : 32'd0;
         if (state == S_LOAD) begin
            tx_shift <= tx_buf;
            bit_idx  <= '0;
         end
         if (state == S_SHIFT_HI && baud_cnt == 16'd0) rx_shift[bit_idx] <= joy_rxd;
         if (state == S_SHIFT_HI && baud_last)         bit_idx <= bit_idx + 3'd1;
      end
   end

   // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr[AW-1:0]] <= rx_shift;
   end

   always_comb begin
      rd_mux = '0;
      case (reg_sel)
         4'h0: rd_mux = fifo_empty ? 32'd0 : {24'd0, fifo_mem[rd_ptr[AW-1:0]]};
         4'h4: rd_mux = {22'd0, irq_flag, 1'b0, ~joy_ack_n, 2'b00, overrun, 1'b0,
                         (state == S_IDLE), !fifo_empty, !tx_full};
         4'h8: rd_mux = {2'b00, ctrl_slot, ctrl_irqen, 10'd0, ctrl_joyn, ctrl_txen, mode};
         4'hC: rd_mux = {baud, 16'd0};
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode       <= '0;
         baud       <= BAUD_RESET;
         ctrl_txen  <= 1'b0;
         ctrl_joyn  <= 1'b0;
         ctrl_irqen <= 1'b0;
         ctrl_slot  <= 1'b0;
         tx_buf     <= '0;
         tx_full    <= 1'b0;
         overrun    <= 1'b0;
         irq_flag   <= 1'b0;
         ren_q      <= 1'b0;
         data_o     <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
      end else begin
         ren_q <= ren;
         if (rd_stb) data_o <= rd_mux;

         if (wen && reg_sel == 4'h8) begin
            if (ben[0]) mode[7:0]  <= data_i[7:0];
            if (ben[1]) mode[15:8] <= data_i[15:8];
            if (ben[2]) {ctrl_joyn, ctrl_txen} <= data_i[17:16];
            if (ben[3]) {ctrl_slot, ctrl_irqen} <= data_i[29:28];
         end
         if (wen && reg_sel == 4'hC) begin
            if (ben[2]) baud[7:0]  <= data_i[23:16];
            if (ben[3]) baud[15:8] <= data_i[31:24];
         end
         if (wr_data) tx_buf <= data_i[7:0];

         if (soft_rst) begin
            tx_full  <= 1'b0;
            overrun  <= 1'b0;
            irq_flag <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
         end else begin
            // Later assignments take priority: a new DATA write beats LOAD, a set beats an ACK clear.
            if (state == S_LOAD) tx_full <= 1'b0;
            if (wr_data)         tx_full <= 1'b1;
            if (ack_wr) begin
               irq_flag <= 1'b0;
               overrun  <= 1'b0;
            end
            if (ovr_set) overrun  <= 1'b1;
            if (ack_set) irq_flag <= 1'b1;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule
